// File: rtl/sum_serial_tx.sv
// sum_serial_tx: FIFO-buffered 5-bit word serializer with start/parity/stop framing
module sum_serial_tx #(
  parameter int DEPTH   = 4,
  parameter int BIT_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               c_i,
  input  logic                     c_valid_i,
  output logic                     c_ready_o,
  output logic                     ser_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t          state_q, state_d;
  logic [4:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     level_q, level_d;
  logic [7:0]      div_q, div_d;
  logic [2:0]      idx_q, idx_d;
  logic [4:0]      sh_q, sh_d;
  logic            par_q, par_d, ser_q, ser_d, ovf_q, ovf_d;
  logic            push, pop, tick;
  assign c_ready_o  = !rst && (level_q < (AW+1)'(DEPTH));
  assign push       = c_valid_i && c_ready_o;
  assign tick       = div_q == 8'(BIT_DIV - 1);
  assign pop        = (level_q != '0) && (state_q == IDLE || (state_q == STOP && tick));
  assign level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
  assign ovf_d      = ovf_q || (c_valid_i && !c_ready_o);
  assign ser_o      = ser_q;
  assign busy_o     = state_q != IDLE;
  assign level_o    = level_q;
  assign overflow_o = ovf_q;
  // FIFO storage: write accepted words at the tail
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= c_i;
  end
  // frame sequencer: load head on pop, advance one bit every BIT_DIV cycles
  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE || tick) ? '0 : div_q + 8'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ser_d   = ser_q;
    if (pop) begin
      state_d = START;
      ser_d   = 1'b0;
      sh_d    = mem_q[rd_q];
      par_d   = ^mem_q[rd_q];
      idx_d   = '0;
    end else if (tick) begin
      case (state_q)
        START: begin
          state_d = DATA;
          ser_d   = sh_q[0];
          sh_d    = sh_q >> 1;
        end
        DATA: begin
          if (idx_q == 3'd4) state_d = PARITY;
          ser_d = (idx_q == 3'd4) ? par_q : sh_q[0];
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 3'd1;
        end
        PARITY: begin
          state_d = STOP;
          ser_d   = 1'b1;
        end
        STOP: begin
          state_d = IDLE;
          ser_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end
  // state registers; reset drops any frame in flight and empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ser_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      level_q <= level_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_sum_serial_tx.sv
// tb_sum_serial_tx: directed and randomized checks of framing, FIFO order, overflow and reset
module tb_sum_serial_tx;
  localparam int BD = 4;
  localparam int DP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] c0 = '0, c1 = '0;
  logic cv0 = 1'b0, cv1 = 1'b0;
  logic rdy0, ser0, busy0, ovf0, rdy1, ser1, busy1, ovf1;
  logic [2:0] lvl0, lvl1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] dec0[$], dec1[$];
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  sum_serial_tx #(.DEPTH(DP), .BIT_DIV(BD)) dut (
    .clk(clk), .rst(rst), .c_i(c0), .c_valid_i(cv0), .c_ready_o(rdy0),
    .ser_o(ser0), .busy_o(busy0), .level_o(lvl0), .overflow_o(ovf0));

  sum_serial_tx #(.DEPTH(DP), .BIT_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .c_i(c1), .c_valid_i(cv1), .c_ready_o(rdy1),
    .ser_o(ser1), .busy_o(busy1), .level_o(lvl1), .overflow_o(ovf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // expected line level for bit k of the frame carrying word w
  function automatic logic fbit(input logic [4:0] w, input int k);
    return (k == 0) ? 1'b0 : (k <= 5) ? w[k-1] : (k == 6) ? ^w : 1'b1;
  endfunction

  // line decoder: samples mid-bit, records {stop, parity_ok, word}; abandons a frame if busy drops
  task automatic monitor(input bit sel, input int bd);
    logic [7:0] b;
    bit ab;
    forever begin
      @(negedge clk);
      if ((sel ? ser1 : ser0) === 1'b0 && (sel ? busy1 : busy0) === 1'b1) begin
        b = '0;
        ab = 1'b0;
        for (int s = 1; s < 8 * bd && !ab; s++) begin
          @(negedge clk);
          if ((sel ? busy1 : busy0) !== 1'b1) ab = 1'b1;
          else if (s % bd == bd / 2) b[s / bd] = sel ? ser1 : ser0;
        end
        if (!ab) begin
          if (sel) dec1.push_back({b[7], b[6] == ^b[5:1], b[5:1]});
          else dec0.push_back({b[7], b[6] == ^b[5:1], b[5:1]});
        end
      end
    end
  endtask

  initial monitor(1'b0, BD);
  initial monitor(1'b1, 1);

  task automatic chk_dec(input string tag, input bit sel);
    chk({tag, "_count"}, sel ? dec1.size() : dec0.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_word"}, (sel ? (i < dec1.size() ? dec1[i] : 7'h0) : (i < dec0.size() ? dec0[i] : 7'h0)),
          {2'b11, exp_q[i]});
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while ((busy0 !== 1'b0 || lvl0 !== 3'd0) && n < lim) begin
      step;
      n++;
    end
    chk({tag, "_drained"}, n < lim, 1);
  endtask

  // push exp_q on consecutive edges and check every cycle of the resulting frames
  task automatic run_frames(input string tag);
    logic [4:0] w[$];
    w = exp_q;
    c0 = w[0];
    cv0 = 1'b1;
    step;
    for (int i = 0; i < 8 * BD * w.size(); i++) begin
      if (i + 1 < w.size()) begin
        c0 = w[i+1];
        cv0 = 1'b1;
      end else begin
        cv0 = 1'b0;
        c0 = 5'($urandom);
      end
      step;
      chk({tag, "_ser"}, ser0, fbit(w[i / (8 * BD)], (i % (8 * BD)) / BD));
      chk({tag, "_busy"}, busy0, 1);
    end
    step;
    chk({tag, "_idle_ser"}, ser0, 1);
    chk({tag, "_idle_busy"}, busy0, 0);
  endtask

  initial begin
    logic [4:0] w;
    int lv;
    bit ov, started, acc, pop;
    rst = 1'b1;
    step;
    step;
    chk("rst_ser", ser0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_level", lvl0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_ser1", ser1, 1);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", rdy0, 1);

    dec0.delete();
    exp_q = '{5'h13};
    run_frames("single");
    chk_dec("single_dec", 1'b0);

    dec0.delete();
    exp_q = '{5'h00, 5'h1F, 5'h0A};
    run_frames("b2b");
    chk_dec("b2b_dec", 1'b0);

    dec0.delete();
    exp_q.delete();
    lv = 0;
    ov = 1'b0;
    started = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w = 5'($urandom);
      c0 = w;
      cv0 = 1'b1;
      acc = lv < DP;
      chk("ovf_ready", rdy0, acc);
      if (acc) exp_q.push_back(w);
      step;
      pop = !started && lv > 0;
      started |= pop;
      lv = lv + int'(acc) - int'(pop);
      ov |= !acc;
      chk("ovf_level", lvl0, lv);
      chk("ovf_flag", ovf0, ov);
      chk("ovf_busy", busy0, started);
    end
    cv0 = 1'b0;
    chk("ovf_ready_full", rdy0, 0);
    wait_idle("ovf", 400);
    chk_dec("ovf_dec", 1'b0);
    chk("ovf_sticky", ovf0, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("ovf_cleared", ovf0, 0);

    dec0.delete();
    for (int k = 0; k < 3; k++) begin
      c0 = 5'($urandom);
      cv0 = 1'b1;
      step;
    end
    cv0 = 1'b0;
    repeat (13) step;
    chk("abort_pre_level", lvl0, 2);
    chk("abort_pre_busy", busy0, 1);
    rst = 1'b1;
    step;
    chk("abort_ser", ser0, 1);
    chk("abort_level", lvl0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_ready", rdy0, 0);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step;
      chk("abort_quiet", {busy0, ser0}, 2'b01);
    end
    chk("abort_dec", dec0.size(), 0);

    dec0.delete();
    exp_q.delete();
    for (int k = 0; k < 3 * DP; k++) begin
      w = 5'($urandom);
      c0 = w;
      cv0 = 1'b1;
      exp_q.push_back(w);
      step;
      cv0 = 1'b0;
      repeat (8 * BD - 1) begin
        c0 = 5'($urandom);
        step;
      end
    end
    wait_idle("wrap", 100);
    chk_dec("wrap_dec", 1'b0);
    chk("wrap_ovf", ovf0, 0);

    dec1.delete();
    exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      w = 5'($urandom);
      c1 = w;
      cv1 = 1'b1;
      exp_q.push_back(w);
      step;
      cv1 = 1'b0;
      chk("fast_level", lvl1 <= 3'd1, 1);
      repeat (7) begin
        c1 = 5'($urandom);
        step;
        chk("fast_level", lvl1 <= 3'd1, 1);
      end
    end
    repeat (12) step;
    chk("fast_busy", busy1, 0);
    chk_dec("fast_dec", 1'b1);
    chk("fast_ovf", ovf1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sum_serial_tx.md
SUM_SERIAL_TX -- requirements
Module: sum_serial_tx

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in words; power of two, 2..16.
REQ-002 Parameter BIT_DIV, default 4, clock cycles per serial bit; range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port c_i  input  5  adder result word from core.
REQ-006 Port c_valid_i  input  1  c_i valid this cycle.
REQ-007 Port c_ready_o  output  1  FIFO can accept a word this cycle.
REQ-008 Port ser_o  output  1  serial line to output pad; idle high.
REQ-009 Port busy_o  output  1  high while a frame is being shifted.
REQ-010 Port level_o  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-011 Port overflow_o  output  1  sticky: c_valid_i seen while c_ready_o low.

Function
REQ-012 Word accepted on an edge where c_valid_i && c_ready_o; written to FIFO tail.
REQ-013 c_ready_o = (level_o < DEPTH), combinational from registered level only.
REQ-014 c_valid_i while full: word dropped, FIFO unchanged, overflow_o set next edge, held until rst.
REQ-015 Frame = 8 bits: start 0, c[0]..c[4] LSB first, even parity (XOR of c[4:0]), stop 1.
REQ-016 Every bit held on ser_o for exactly BIT_DIV cycles; frame = 8*BIT_DIV cycles.
REQ-017 FSM states IDLE, START, DATA, PARITY, STOP; ser_o registered.
REQ-018 IDLE -> START on edge when FIFO non-empty; head popped into shift register on that edge.
REQ-019 START -> DATA, DATA -> PARITY after 5th data bit, PARITY -> STOP, each after BIT_DIV cycles.
REQ-020 STOP -> START directly (back-to-back, no idle gap) if FIFO non-empty at end of stop bit; else -> IDLE.
REQ-021 Latency: word accepted at edge N into empty FIFO with FSM IDLE -> ser_o low from edge N+1.
REQ-022 busy_o high in START/DATA/PARITY/STOP, low in IDLE.
REQ-023 Simultaneous push and pop in one edge: level_o unchanged; allowed when full (pop frees slot, but c_ready_o still low that cycle, so push dropped and overflow set).
REQ-024 Pointers wrap modulo DEPTH; order strictly FIFO.
REQ-025 c_i/c_valid_i changes mid-frame have no effect on the frame in progress.

Reset
REQ-026 On rst high at an edge: FSM IDLE, FIFO empty, level_o 0, ser_o 1, busy_o 0, overflow_o 0, bit counters 0.
REQ-027 rst mid-frame aborts the frame immediately; ser_o 1 on next cycle; queued words discarded.
REQ-028 c_valid_i ignored (no write) on any edge where rst is high; c_ready_o 0 while rst high.

Verification
REQ-029 BIT_DIV=4, push c_i=5'h13 once -> ser_o: 0(4) 1 1 0 0 1 (4 each) parity 1(4) stop 1(4); busy_o 32 cycles.
REQ-030 Push 5'h00, 5'h1F, 5'h0A on consecutive cycles -> three frames back-to-back, no idle gap, parities 0,1,0, order preserved.
REQ-031 Push 6 words with DEPTH=4, BIT_DIV=4 consecutively -> first pops on edge 1; c_ready_o low after 5th accepted; 6th dropped, overflow_o 1, level_o 4.
REQ-032 Assert rst during DATA bit 2 of a frame with 2 queued -> ser_o 1 next cycle, level_o 0, busy_o 0, no further frames.
REQ-033 BIT_DIV=1, continuous pushes of random c_i at 1/8 rate -> serial decoder model recovers every word with correct parity, level_o never exceeds 1.
REQ-034 Wrap test: 3*DEPTH words at rate matching drain -> pointers wrap, decoded sequence equals pushed sequence, overflow_o stays 0.
